// File: rtl/s_mem_check_fsm.sv
// Reads back all 256 S-memory entries and checks them as an identity map or as a
// duplicate-free permutation, reporting a verdict plus first-error diagnostics.
`timescale 1ns/1ps
module s_mem_check_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_chk,
  input  logic       mode,
  input  logic [7:0] q,
  output logic [7:0] address,
  output logic       wren,
  output logic       busy,
  output logic       finish,
  output logic       pass,
  output logic [7:0] err_addr,
  output logic [8:0] err_count
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StDone} state_e;

  state_e       state_q, state_d;
  logic         mode_q, mode_d;
  logic [7:0]   idx_q, idx_d;
  logic [255:0] seen_q, seen_d;
  logic [8:0]   err_count_q, err_count_d;
  logic [7:0]   err_addr_q, err_addr_d;
  logic         pass_q, pass_d;
  logic [7:0]   address_q, address_d;
  logic         entry_err;

  // Permutation mode flags a value already seen earlier in this run
  assign entry_err = mode_q ? seen_q[q] : (q != idx_q);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    seen_d      = seen_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    pass_d      = pass_q;
    address_d   = address_q;
    unique case (state_q)
      StIdle: begin
        if (start_chk) begin
          mode_d      = mode;
          idx_d       = 8'd0;
          seen_d      = '0;
          err_count_d = 9'd0;
          err_addr_d  = 8'd0;
          pass_d      = 1'b0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        address_d = idx_q;
        state_d   = StWait;
      end
      StWait: state_d = StCheck;
      StCheck: begin
        if (mode_q) seen_d[q] = 1'b1;
        if (entry_err) begin
          err_count_d = err_count_q + 9'd1;
          if (err_count_q == 9'd0) err_addr_d = idx_q;
        end
        if (idx_q == 8'hff) begin
          // Verdict is registered here so it is already valid during DONE
          pass_d  = (err_count_d == 9'd0);
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = StIssue;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      idx_q       <= 8'd0;
      seen_q      <= '0;
      err_count_q <= 9'd0;
      err_addr_q  <= 8'd0;
      pass_q      <= 1'b0;
      address_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      seen_q      <= seen_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      pass_q      <= pass_d;
      address_q   <= address_d;
    end
  end

  assign address   = address_q;
  assign wren      = 1'b0;
  assign busy      = (state_q != StIdle);
  assign finish    = (state_q == StDone);
  assign pass      = pass_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule
